// File: rtl/data_path.sv
// TI170 8-bit datapath: IR/MAR/PC/A/B/CCR, Bus1/Bus2 muxes, ALU; `DATAPATH_ALU_EXT_EN enables INC/DEC/XOR/NOT.
// Latency: buses, ALU and to_memory are combinational; register loads are visible one cycle after the strobe.
// Backpressure: none; strobes are single-cycle levels sampled on the rising clock edge.
module data_path (
    input  logic       clock,
    input  logic       reset,
    input  logic       IR_Load,
    input  logic       MAR_Load,
    input  logic       PC_Load,
    input  logic       PC_Inc,
    input  logic       A_Load,
    input  logic       B_Load,
    input  logic       CCR_Load,
    input  logic [2:0] ALU_Sel,
    input  logic [1:0] Bus1_Sel,
    input  logic [1:0] Bus2_Sel,
    input  logic [7:0] from_memory,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic [7:0] IR,
    output logic [3:0] CCR_Result
);

    logic [7:0] ir_q,  ir_d;
    logic [7:0] mar_q, mar_d;
    logic [7:0] pc_q,  pc_d;
    logic [7:0] a_q,   a_d;
    logic [7:0] b_q,   b_d;
    logic [3:0] ccr_q, ccr_d;

    logic [7:0] bus1;
    logic [7:0] bus2;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [8:0] alu_wide;
    logic [7:0] alu_res;
    logic       alu_v;
    logic       alu_c;
    logic       alu_flags_ok;

    always_comb begin
        bus1 = 8'h00;
        case (Bus1_Sel)
            2'b00:   bus1 = pc_q;
            2'b01:   bus1 = a_q;
            2'b10:   bus1 = b_q;
            default: bus1 = 8'h00;
        endcase
    end

    assign alu_x = b_q;
    assign alu_y = bus1;

    // C holds carry for add-type ops and borrow for subtract-type ops; bit 8 of the
    // 9-bit difference is exactly the borrow.
    always_comb begin
        alu_wide     = 9'h000;
        alu_res      = 8'h00;
        alu_v        = 1'b0;
        alu_c        = 1'b0;
        alu_flags_ok = 1'b1;
        case (ALU_Sel)
            3'b000: begin
                alu_wide = {1'b0, alu_x} + {1'b0, alu_y};
                alu_res  = alu_wide[7:0];
                alu_c    = alu_wide[8];
                alu_v    = (alu_x[7] == alu_y[7]) && (alu_res[7] != alu_x[7]);
            end
            3'b001: begin
                alu_wide = {1'b0, alu_x} - {1'b0, alu_y};
                alu_res  = alu_wide[7:0];
                alu_c    = alu_wide[8];
                alu_v    = (alu_x[7] != alu_y[7]) && (alu_res[7] != alu_x[7]);
            end
            3'b010: alu_res = alu_x & alu_y;
            3'b011: alu_res = alu_x | alu_y;
`ifdef DATAPATH_ALU_EXT_EN
            3'b100: begin
                alu_wide = {1'b0, alu_x} + 9'd1;
                alu_res  = alu_wide[7:0];
                alu_c    = alu_wide[8];
                alu_v    = alu_res[7] & ~alu_x[7];
            end
            3'b101: begin
                alu_wide = {1'b0, alu_x} - 9'd1;
                alu_res  = alu_wide[7:0];
                alu_c    = alu_wide[8];
                alu_v    = alu_x[7] & ~alu_res[7];
            end
            3'b110: alu_res = alu_x ^ alu_y;
            default: alu_res = ~alu_x;
`else
            // Extended codes are unimplemented: zero result and the CCR is left alone.
            default: begin
                alu_res      = 8'h00;
                alu_flags_ok = 1'b0;
            end
`endif
        endcase
    end

    always_comb begin
        bus2 = 8'h00;
        case (Bus2_Sel)
            2'b00:   bus2 = alu_res;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = from_memory;
            default: bus2 = 8'h00;
        endcase
    end

    always_comb begin
        ir_d  = IR_Load  ? bus2 : ir_q;
        mar_d = MAR_Load ? bus2 : mar_q;
        a_d   = A_Load   ? bus2 : a_q;
        b_d   = B_Load   ? bus2 : b_q;
        pc_d  = pc_q;
        if (PC_Load) begin
            pc_d = bus2;
        end else if (PC_Inc) begin
            pc_d = pc_q + 8'd1;
        end
        ccr_d = ccr_q;
        if (CCR_Load && alu_flags_ok) begin
            ccr_d = {alu_res[7], (alu_res == 8'h00), alu_v, alu_c};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_q  <= 8'h00;
            mar_q <= 8'h00;
            pc_q  <= 8'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            ccr_q <= 4'h0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign address    = mar_q;
    assign to_memory  = bus1;
    assign IR         = ir_q;
    assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: reset, fetch, PC wrap/priority, ALU flags, multi-load, extended ALU codes.
module tb_data_path;

    logic       clock;
    logic       reset;
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load;
    logic [2:0] alu_sel;
    logic [1:0] bus1_sel;
    logic [1:0] bus2_sel;
    logic [7:0] from_memory;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic [7:0] ir;
    logic [3:0] ccr;

    int n_checks = 0;
    int n_fail   = 0;

    data_path dut (
        .clock       (clock),
        .reset       (reset),
        .IR_Load     (ir_load),
        .MAR_Load    (mar_load),
        .PC_Load     (pc_load),
        .PC_Inc      (pc_inc),
        .A_Load      (a_load),
        .B_Load      (b_load),
        .CCR_Load    (ccr_load),
        .ALU_Sel     (alu_sel),
        .Bus1_Sel    (bus1_sel),
        .Bus2_Sel    (bus2_sel),
        .from_memory (from_memory),
        .address     (address),
        .to_memory   (to_memory),
        .IR          (ir),
        .CCR_Result  (ccr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0;
        a_load = 0; b_load = 0; ccr_load = 0;
        alu_sel = 3'b000; bus1_sel = 2'b00; bus2_sel = 2'b00; from_memory = 8'h00;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // which: 0=A 1=B 2=PC 3=IR 4=MAR, loaded from memory through Bus2.
    task automatic set_reg(input int which, input logic [7:0] v);
        idle();
        bus2_sel = 2'b10;
        from_memory = v;
        case (which)
            0: a_load = 1;
            1: b_load = 1;
            2: pc_load = 1;
            3: ir_load = 1;
            default: mar_load = 1;
        endcase
        tick();
        idle();
    endtask

    // ALU result lands in IR; CCR optionally captures the flags.
    task automatic run_alu(input logic [2:0] op, input logic [1:0] b1, input logic ccr_ld);
        idle();
        alu_sel = op; bus1_sel = b1; bus2_sel = 2'b00; ir_load = 1; ccr_load = ccr_ld;
        tick();
        idle();
    endtask

    task automatic test_reset();
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL rst_address: got %h want 00", address); end
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL rst_ir: got %h want 00", ir); end
        n_checks++; if (ccr !== 4'h0) begin n_fail++; $display("FAIL rst_ccr: got %h want 0", ccr); end
        n_checks++; if (to_memory !== 8'h00) begin n_fail++; $display("FAIL rst_to_memory: got %h want 00", to_memory); end
        reset = 1'b1;
        tick();
        set_reg(0, 8'h5A);
        set_reg(2, 8'h10);
        set_reg(3, 8'h33);
        set_reg(4, 8'h44);
        bus1_sel = 2'b01; #1;
        n_checks++; if (to_memory !== 8'h5A) begin n_fail++; $display("FAIL pre_rst_a: got %h want 5a", to_memory); end
        bus1_sel = 2'b00; #1;
        n_checks++; if (to_memory !== 8'h10) begin n_fail++; $display("FAIL pre_rst_pc: got %h want 10", to_memory); end
        reset = 1'b0; #1;
        n_checks++; if (to_memory !== 8'h00) begin n_fail++; $display("FAIL async_rst_pc: got %h want 00", to_memory); end
        bus1_sel = 2'b01; #1;
        n_checks++; if (to_memory !== 8'h00) begin n_fail++; $display("FAIL async_rst_a: got %h want 00", to_memory); end
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL async_rst_mar: got %h want 00", address); end
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL async_rst_ir: got %h want 00", ir); end
        idle();
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL post_rst_address: got %h want 00", address); end
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL post_rst_ir: got %h want 00", ir); end
    endtask

    task automatic test_fetch();
        idle();
        bus1_sel = 2'b00; bus2_sel = 2'b01; mar_load = 1;
        tick();
        idle(); pc_inc = 1;
        tick();
        idle(); bus2_sel = 2'b10; from_memory = 8'h86; ir_load = 1;
        tick();
        idle(); #1;
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL fetch_mar: got %h want 00", address); end
        n_checks++; if (ir !== 8'h86) begin n_fail++; $display("FAIL fetch_ir: got %h want 86", ir); end
        n_checks++; if (to_memory !== 8'h01) begin n_fail++; $display("FAIL fetch_pc: got %h want 01", to_memory); end
    endtask

    task automatic test_pc();
        set_reg(2, 8'hFF);
        pc_inc = 1;
        tick();
        idle(); #1;
        n_checks++; if (to_memory !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got %h want 00", to_memory); end
        pc_load = 1; pc_inc = 1; bus2_sel = 2'b10; from_memory = 8'h40;
        tick();
        idle(); #1;
        n_checks++; if (to_memory !== 8'h40) begin n_fail++; $display("FAIL pc_load_wins: got %h want 40", to_memory); end
        pc_inc = 1;
        tick();
        idle(); #1;
        n_checks++; if (to_memory !== 8'h41) begin n_fail++; $display("FAIL pc_inc: got %h want 41", to_memory); end
        tick(); #1;
        n_checks++; if (to_memory !== 8'h41) begin n_fail++; $display("FAIL pc_hold: got %h want 41", to_memory); end
    endtask

    task automatic test_alu();
        set_reg(1, 8'h7F); set_reg(0, 8'h01);
        run_alu(3'b000, 2'b01, 1);
        n_checks++; if (ir !== 8'h80) begin n_fail++; $display("FAIL add_ovf_res: got %h want 80", ir); end
        n_checks++; if (ccr !== 4'b1010) begin n_fail++; $display("FAIL add_ovf_ccr: got %b want 1010", ccr); end
        set_reg(1, 8'hFF);
        run_alu(3'b000, 2'b01, 1);
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL add_carry_res: got %h want 00", ir); end
        n_checks++; if (ccr !== 4'b0101) begin n_fail++; $display("FAIL add_carry_ccr: got %b want 0101", ccr); end
        set_reg(1, 8'h00);
        run_alu(3'b001, 2'b01, 1);
        n_checks++; if (ir !== 8'hFF) begin n_fail++; $display("FAIL sub_borrow_res: got %h want ff", ir); end
        n_checks++; if (ccr !== 4'b1001) begin n_fail++; $display("FAIL sub_borrow_ccr: got %b want 1001", ccr); end
        set_reg(1, 8'h80);
        run_alu(3'b001, 2'b01, 1);
        n_checks++; if (ir !== 8'h7F) begin n_fail++; $display("FAIL sub_ovf_res: got %h want 7f", ir); end
        n_checks++; if (ccr !== 4'b0010) begin n_fail++; $display("FAIL sub_ovf_ccr: got %b want 0010", ccr); end
        set_reg(1, 8'h05); set_reg(0, 8'h03);
        run_alu(3'b001, 2'b01, 1);
        n_checks++; if (ir !== 8'h02) begin n_fail++; $display("FAIL sub_plain_res: got %h want 02", ir); end
        n_checks++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL sub_plain_ccr: got %b want 0000", ccr); end
        set_reg(1, 8'hF0); set_reg(0, 8'h0F);
        run_alu(3'b010, 2'b01, 1);
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL and_res: got %h want 00", ir); end
        n_checks++; if (ccr !== 4'b0100) begin n_fail++; $display("FAIL and_ccr: got %b want 0100", ccr); end
        run_alu(3'b011, 2'b01, 0);
        n_checks++; if (ir !== 8'hFF) begin n_fail++; $display("FAIL or_res: got %h want ff", ir); end
        n_checks++; if (ccr !== 4'b0100) begin n_fail++; $display("FAIL ccr_hold: got %b want 0100", ccr); end
        set_reg(1, 8'h40);
        run_alu(3'b000, 2'b10, 1);
        n_checks++; if (ir !== 8'h80) begin n_fail++; $display("FAIL add_bus1_b: got %h want 80", ir); end
        set_reg(1, 8'h12);
        run_alu(3'b000, 2'b11, 1);
        n_checks++; if (ir !== 8'h12) begin n_fail++; $display("FAIL add_bus1_zero: got %h want 12", ir); end
        n_checks++; if (ccr !== 4'b0000) begin n_fail++; $display("FAIL add_bus1_zero_ccr: got %b want 0000", ccr); end
    endtask

    task automatic test_multi_load();
        set_reg(1, 8'h03); set_reg(0, 8'h05);
        idle(); alu_sel = 3'b000; bus1_sel = 2'b01; bus2_sel = 2'b00;
        a_load = 1; b_load = 1; ir_load = 1; mar_load = 1;
        #1;
        n_checks++; if (to_memory !== 8'h05) begin n_fail++; $display("FAIL comb_to_memory: got %h want 05", to_memory); end
        tick();
        idle(); #1;
        n_checks++; if (ir !== 8'h08) begin n_fail++; $display("FAIL multi_ir: got %h want 08", ir); end
        n_checks++; if (address !== 8'h08) begin n_fail++; $display("FAIL multi_mar: got %h want 08", address); end
        bus1_sel = 2'b01; #1;
        n_checks++; if (to_memory !== 8'h08) begin n_fail++; $display("FAIL multi_a: got %h want 08", to_memory); end
        bus1_sel = 2'b10; #1;
        n_checks++; if (to_memory !== 8'h08) begin n_fail++; $display("FAIL multi_b: got %h want 08", to_memory); end
        run_alu(3'b000, 2'b01, 0);
        n_checks++; if (ir !== 8'h10) begin n_fail++; $display("FAIL rbw_next: got %h want 10", ir); end
        idle(); bus2_sel = 2'b11; mar_load = 1;
        tick();
        idle(); #1;
        n_checks++; if (address !== 8'h00) begin n_fail++; $display("FAIL bus2_zero: got %h want 00", address); end
        idle(); bus1_sel = 2'b10; bus2_sel = 2'b01; ir_load = 1;
        tick();
        idle(); #1;
        n_checks++; if (ir !== 8'h08) begin n_fail++; $display("FAIL bus2_bus1: got %h want 08", ir); end
    endtask

    task automatic test_ext();
        logic [7:0] exp_res [4];
        logic [3:0] exp_ccr [4];
`ifdef DATAPATH_ALU_EXT_EN
        exp_res[0] = 8'h10; exp_ccr[0] = 4'b0000;
        exp_res[1] = 8'h7F; exp_ccr[1] = 4'b0010;
        exp_res[2] = 8'h0F; exp_ccr[2] = 4'b0000;
        exp_res[3] = 8'hF0; exp_ccr[3] = 4'b1000;
`else
        for (int i = 0; i < 4; i++) begin exp_res[i] = 8'h00; exp_ccr[i] = 4'b0101; end
`endif
        set_reg(1, 8'hFF); set_reg(0, 8'h01);
        run_alu(3'b000, 2'b01, 1);
        set_reg(1, 8'h0F);
        run_alu(3'b100, 2'b00, 1);
        n_checks++; if (ir !== exp_res[0]) begin n_fail++; $display("FAIL inc_res: got %h want %h", ir, exp_res[0]); end
        n_checks++; if (ccr !== exp_ccr[0]) begin n_fail++; $display("FAIL inc_ccr: got %b want %b", ccr, exp_ccr[0]); end
`ifndef DATAPATH_ALU_EXT_EN
        exp_ccr[1] = 4'b0101;
`endif
        set_reg(1, 8'h80);
        run_alu(3'b101, 2'b00, 1);
        n_checks++; if (ir !== exp_res[1]) begin n_fail++; $display("FAIL dec_res: got %h want %h", ir, exp_res[1]); end
        n_checks++; if (ccr !== exp_ccr[1]) begin n_fail++; $display("FAIL dec_ccr: got %b want %b", ccr, exp_ccr[1]); end
        set_reg(1, 8'hF0); set_reg(0, 8'hFF);
        run_alu(3'b110, 2'b01, 1);
        n_checks++; if (ir !== exp_res[2]) begin n_fail++; $display("FAIL xor_res: got %h want %h", ir, exp_res[2]); end
        n_checks++; if (ccr !== exp_ccr[2]) begin n_fail++; $display("FAIL xor_ccr: got %b want %b", ccr, exp_ccr[2]); end
        set_reg(1, 8'h0F);
        run_alu(3'b111, 2'b01, 1);
        n_checks++; if (ir !== exp_res[3]) begin n_fail++; $display("FAIL not_res: got %h want %h", ir, exp_res[3]); end
        n_checks++; if (ccr !== exp_ccr[3]) begin n_fail++; $display("FAIL not_ccr: got %b want %b", ccr, exp_ccr[3]); end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        test_reset();
        test_fetch();
        test_pc();
        test_alu();
        test_multi_load();
        test_ext();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
